// File: rtl/ps2_key_ctrl_pkg.sv
// Shared types for the PS/2 key sequencer: FSM encoding, Set-2 prefix bytes
// and the key event record handed to consumers.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_DEC  = 2'd2,
    ST_EMIT = 2'd3
  } state_t;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } key_event_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == SC_EXT) || (b == SC_BRK);
  endfunction

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// FIFO-side pop handshake and consumer-side key event handshake.
interface ps2_key_ctrl_if;
  logic       kbd_ready;
  logic [7:0] kbd_data;
  logic       kbd_overflow;
  logic       kbd_nextdata_n;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_release;

  modport master (
    output kbd_ready, kbd_data, kbd_overflow, ev_ready,
    input  kbd_nextdata_n, ev_valid, ev_code, ev_ext, ev_release
  );

  modport slave (
    input  kbd_ready, kbd_data, kbd_overflow, ev_ready,
    output kbd_nextdata_n, ev_valid, ev_code, ev_ext, ev_release
  );
endinterface

// File: rtl/ps2_key_ctrl_prefix_decode.sv
// Combinational classifier of the captured byte against the pending prefix
// flags and the currently held key.
module ps2_prefix_decode
  import ps2_pkg::*;
#(
  parameter int REPEAT_FILTER = 1
) (
  input  logic [7:0] byte_r,
  input  logic       ext_f,
  input  logic       brk_f,
  input  logic       held_valid,
  input  logic [7:0] held_code,
  input  logic       held_ext,
  output logic       is_ext,
  output logic       is_brk,
  output logic       is_repeat,
  output logic       is_release
);

  logic prefix_s;
  logic held_match_s;

  // Classify the byte; a repeat is a make code equal to the held {code, ext}
  always_comb begin
    is_ext       = (byte_r == SC_EXT);
    is_brk       = (byte_r == SC_BRK);
    prefix_s     = is_prefix(byte_r);
    held_match_s = held_valid && (held_code == byte_r) && (held_ext == ext_f);
    is_release   = !prefix_s && brk_f;
    is_repeat    = (REPEAT_FILTER != 0) && !prefix_s && !brk_f && held_match_s;
  end

endmodule

// File: rtl/ps2_key_ctrl.sv
// Drains the ps2_keyboard FIFO one byte at a time, folds E0/F0 prefixes into
// single key events, filters auto-repeat and tracks the held key.
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int REPEAT_FILTER = 1
) (
  input  logic          clk,
  input  logic          clrn,
  ps2_key_ctrl_if.slave kbd,
  output logic          held_valid,
  output logic [7:0]    held_code,
  output logic [7:0]    press_count,
  output logic          ovf_sticky,
  input  logic          ovf_clr
);

  state_t     state_r, state_s;
  logic [7:0] byte_r;
  logic       ext_f_r, brk_f_r;
  logic       nd_n_r, ev_valid_r;
  key_event_t ev_r;
  logic       held_valid_r, held_ext_r;
  logic [7:0] held_code_r, press_count_r;
  logic       ovf_sticky_r, ovf_prev_r;
  logic       is_ext_s, is_brk_s, is_repeat_s, is_release_s;
  logic       emit_s, ovf_rise_s, rel_match_s;

  ps2_prefix_decode #(.REPEAT_FILTER(REPEAT_FILTER)) u_dec (
    .byte_r     (byte_r),
    .ext_f      (ext_f_r),
    .brk_f      (brk_f_r),
    .held_valid (held_valid_r),
    .held_code  (held_code_r),
    .held_ext   (held_ext_r),
    .is_ext     (is_ext_s),
    .is_brk     (is_brk_s),
    .is_repeat  (is_repeat_s),
    .is_release (is_release_s)
  );

  // Next-state logic and decode-cycle qualifiers
  always_comb begin
    state_s     = state_r;
    emit_s      = !is_ext_s && !is_brk_s && !is_repeat_s;
    ovf_rise_s  = kbd.kbd_overflow && !ovf_prev_r;
    rel_match_s = held_valid_r && (held_code_r == byte_r) && (held_ext_r == ext_f_r);
    case (state_r)
      ST_IDLE: if (kbd.kbd_ready) state_s = ST_ACK; else state_s = ST_IDLE;
      ST_ACK:  state_s = ST_DEC;
      ST_DEC:  if (emit_s) state_s = ST_EMIT; else state_s = ST_IDLE;
      ST_EMIT: if (kbd.ev_ready) state_s = ST_IDLE; else state_s = ST_EMIT;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, handshake strobes, prefix flags, event and held-key registers
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      state_r       <= ST_IDLE;
      byte_r        <= 8'h00;
      ext_f_r       <= 1'b0;
      brk_f_r       <= 1'b0;
      nd_n_r        <= 1'b1;
      ev_valid_r    <= 1'b0;
      ev_r          <= '0;
      held_valid_r  <= 1'b0;
      held_ext_r    <= 1'b0;
      held_code_r   <= 8'h00;
      press_count_r <= 8'h00;
      ovf_sticky_r  <= 1'b0;
      ovf_prev_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      nd_n_r     <= (state_s != ST_ACK);
      ev_valid_r <= (state_s == ST_EMIT);
      ovf_prev_r <= kbd.kbd_overflow;
      if (kbd.kbd_overflow) ovf_sticky_r <= 1'b1;
      else if (ovf_clr)     ovf_sticky_r <= 1'b0;
      if ((state_r == ST_IDLE) && kbd.kbd_ready) byte_r <= kbd.kbd_data;
      // An overflow edge means bytes were lost, so a half-built prefix is stale
      if (ovf_rise_s) begin
        ext_f_r <= 1'b0;
        brk_f_r <= 1'b0;
      end else if (state_r == ST_DEC) begin
        if (is_ext_s)      ext_f_r <= 1'b1;
        else if (is_brk_s) brk_f_r <= 1'b1;
        else begin
          ext_f_r <= 1'b0;
          brk_f_r <= 1'b0;
        end
      end
      if ((state_r == ST_DEC) && emit_s) begin
        ev_r.code <= byte_r;
        ev_r.ext  <= ext_f_r;
        ev_r.rel  <= is_release_s;
        if (is_release_s) begin
          if (rel_match_s) held_valid_r <= 1'b0;
        end else begin
          held_valid_r  <= 1'b1;
          held_code_r   <= byte_r;
          held_ext_r    <= ext_f_r;
          press_count_r <= press_count_r + 8'd1;
        end
      end
    end
  end

  assign kbd.kbd_nextdata_n = nd_n_r;
  assign kbd.ev_valid       = ev_valid_r;
  assign kbd.ev_code        = ev_r.code;
  assign kbd.ev_ext         = ev_r.ext;
  assign kbd.ev_release     = ev_r.rel;
  assign held_valid         = held_valid_r;
  assign held_code          = held_code_r;
  assign press_count        = press_count_r;
  assign ovf_sticky         = ovf_sticky_r;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Bench for ps2_key_ctrl: two instances (repeat filter on / off) share one
// byte stream; a FIFO model feeds them and a key-event model predicts results.
module tb_ps2_key_ctrl;

  logic clk = 1'b0;
  logic clrn, ovf, ovf_clr;
  logic rdy [2];
  logic [7:0] dat [2];
  logic erdy [2];
  logic nd_n [2], evv [2], evx [2], evr [2], hv [2], ovs [2];
  logic [7:0] evc [2], hc [2], pc [2];

  ps2_key_ctrl_if ifa ();
  ps2_key_ctrl_if ifb ();

  assign ifa.kbd_ready = rdy[0];  assign ifb.kbd_ready = rdy[1];
  assign ifa.kbd_data  = dat[0];  assign ifb.kbd_data  = dat[1];
  assign ifa.kbd_overflow = ovf;  assign ifb.kbd_overflow = ovf;
  assign ifa.ev_ready  = erdy[0]; assign ifb.ev_ready  = erdy[1];
  assign nd_n[0] = ifa.kbd_nextdata_n; assign nd_n[1] = ifb.kbd_nextdata_n;
  assign evv[0]  = ifa.ev_valid;       assign evv[1]  = ifb.ev_valid;
  assign evc[0]  = ifa.ev_code;        assign evc[1]  = ifb.ev_code;
  assign evx[0]  = ifa.ev_ext;         assign evx[1]  = ifb.ev_ext;
  assign evr[0]  = ifa.ev_release;     assign evr[1]  = ifb.ev_release;

  ps2_key_ctrl #(.REPEAT_FILTER(1)) dut_a (
    .clk(clk), .clrn(clrn), .kbd(ifa), .held_valid(hv[0]), .held_code(hc[0]),
    .press_count(pc[0]), .ovf_sticky(ovs[0]), .ovf_clr(ovf_clr)
  );
  ps2_key_ctrl #(.REPEAT_FILTER(0)) dut_b (
    .clk(clk), .clrn(clrn), .kbd(ifb), .held_valid(hv[1]), .held_code(hc[1]),
    .press_count(pc[1]), .ovf_sticky(ovs[1]), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit rnd_rdy = 1'b0;

  logic [7:0] stream [$];
  int rd [2], lowcnt [2], ev_wr [2], ev_rd [2];
  bit pop_p [2], hold [2];
  logic [9:0] snap [2];
  logic [9:0] exp_ev [2][0:1023];
  logic m_ext [2], m_brk [2], m_hv [2], m_hx [2];
  logic [7:0] m_hc [2], m_cnt [2];

  task automatic refresh();
    for (int d = 0; d < 2; d++) begin
      rdy[d] = (rd[d] < stream.size());
      dat[d] = rdy[d] ? stream[rd[d]] : 8'h00;
    end
  endtask

  task automatic clear_tb();
    stream.delete();
    for (int d = 0; d < 2; d++) begin
      rd[d] = 0; lowcnt[d] = 0; ev_wr[d] = 0; ev_rd[d] = 0;
      pop_p[d] = 1'b0; hold[d] = 1'b0;
      m_ext[d] = 1'b0; m_brk[d] = 1'b0; m_hv[d] = 1'b0; m_hx[d] = 1'b0;
      m_hc[d] = 8'h00; m_cnt[d] = 8'h00;
    end
    refresh();
  endtask

  task automatic expect_ev(input int d, input logic [9:0] e);
    exp_ev[d][ev_wr[d] % 1024] = e;
    ev_wr[d]++;
  endtask

  // Key-event rules applied to the byte stream in arrival order
  task automatic model(input int d, input logic [7:0] b);
    bit rf = (d == 0);
    bit match;
    if (b == 8'hE0) m_ext[d] = 1'b1;
    else if (b == 8'hF0) m_brk[d] = 1'b1;
    else begin
      match = m_hv[d] && (m_hc[d] == b) && (m_hx[d] == m_ext[d]);
      if (m_brk[d]) begin
        expect_ev(d, {b, m_ext[d], 1'b1});
        if (match) m_hv[d] = 1'b0;
      end else if (!(rf && match)) begin
        expect_ev(d, {b, m_ext[d], 1'b0});
        m_hv[d] = 1'b1; m_hc[d] = b; m_hx[d] = m_ext[d];
        m_cnt[d] = m_cnt[d] + 8'd1;
      end
      m_ext[d] = 1'b0; m_brk[d] = 1'b0;
    end
  endtask

  task automatic push(input logic [7:0] b);
    stream.push_back(b);
    model(0, b);
    model(1, b);
    refresh();
  endtask

  // One clock: score events accepted at this edge, then model the FIFO pop
  task automatic tick();
    for (int d = 0; d < 2; d++) begin
      hold[d] = 1'b0;
      if (evv[d] === 1'b1 && erdy[d] === 1'b1) begin
        n_cmp++;
        if (ev_rd[d] == ev_wr[d]) begin
          n_err++;
          $display("FAIL event dut%0d: got %h want none", d, {evc[d], evx[d], evr[d]});
        end else begin
          if ({evc[d], evx[d], evr[d]} !== exp_ev[d][ev_rd[d] % 1024]) begin
            n_err++;
            $display("FAIL event dut%0d: got %h want %h", d,
                     {evc[d], evx[d], evr[d]}, exp_ev[d][ev_rd[d] % 1024]);
          end
          ev_rd[d]++;
        end
      end else if (evv[d] === 1'b1) begin
        hold[d] = 1'b1;
        snap[d] = {evc[d], evx[d], evr[d]};
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (pop_p[d]) rd[d]++;
      pop_p[d] = (nd_n[d] === 1'b0);
      if (pop_p[d]) lowcnt[d]++;
      if (hold[d]) begin
        n_cmp++;
        if (evv[d] !== 1'b1 || {evc[d], evx[d], evr[d]} !== snap[d]) begin
          n_err++;
          $display("FAIL stall_stable dut%0d: got %b/%h want 1/%h", d, evv[d],
                   {evc[d], evx[d], evr[d]}, snap[d]);
        end
        n_cmp++;
        if (nd_n[d] !== 1'b1) begin
          n_err++;
          $display("FAIL pop_in_emit dut%0d: got %b want 1", d, nd_n[d]);
        end
      end
      if (rnd_rdy) erdy[d] = 1'($urandom_range(0, 1));
    end
    refresh();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    bit busy = 1'b1;
    while (busy && n < budget) begin
      busy = 1'b0;
      for (int d = 0; d < 2; d++)
        if (rd[d] < stream.size() || ev_rd[d] != ev_wr[d] || evv[d] || pop_p[d]) busy = 1'b1;
      if (busy) begin tick(); n++; end
    end
    if (busy) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: got %0d cycles want < %0d", n, budget);
    end
    repeat (4) tick();
  endtask

  task automatic check_state(input string name);
    for (int d = 0; d < 2; d++) begin
      n_cmp += 5;
      if (hv[d] !== m_hv[d]) begin n_err++;
        $display("FAIL %s held_valid dut%0d: got %b want %b", name, d, hv[d], m_hv[d]); end
      if (hc[d] !== m_hc[d]) begin n_err++;
        $display("FAIL %s held_code dut%0d: got %h want %h", name, d, hc[d], m_hc[d]); end
      if (pc[d] !== m_cnt[d]) begin n_err++;
        $display("FAIL %s press_count dut%0d: got %0d want %0d", name, d, pc[d], m_cnt[d]); end
      if (lowcnt[d] != stream.size()) begin n_err++;
        $display("FAIL %s pop_cycles dut%0d: got %0d want %0d", name, d, lowcnt[d], stream.size()); end
      if (ev_rd[d] != ev_wr[d]) begin n_err++;
        $display("FAIL %s events_seen dut%0d: got %0d want %0d", name, d, ev_rd[d], ev_wr[d]); end
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if ({nd_n[d], evv[d], evc[d], evx[d], evr[d], hv[d], hc[d], pc[d], ovs[d]} !==
          {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0}) begin
        n_err++;
        $display("FAIL reset_values dut%0d: got nd_n=%b v=%b code=%h ext=%b rel=%b hv=%b hc=%h pc=%h ovf=%b want 1/0/00/0/0/0/00/00/0",
                 d, nd_n[d], evv[d], evc[d], evx[d], evr[d], hv[d], hc[d], pc[d], ovs[d]);
      end
    end
  endtask

  task automatic test_make_break();
    erdy[0] = 1'b1; erdy[1] = 1'b1;
    push(8'h1C);
    tick();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (nd_n[d] !== 1'b0) begin n_err++;
        $display("FAIL latency_ack dut%0d: got %b want 0", d, nd_n[d]); end
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (evv[d] !== 1'b0) begin n_err++;
        $display("FAIL latency_dec dut%0d: got %b want 0", d, evv[d]); end
    end
    tick();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (evv[d] !== 1'b1) begin n_err++;
        $display("FAIL latency_emit dut%0d: got %b want 1", d, evv[d]); end
    end
    drain(200);
    check_state("make");
    push(8'hF0); push(8'h1C);
    drain(200);
    check_state("break");
  endtask

  task automatic test_ext();
    rnd_rdy = 1'b1;
    push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
    drain(500);
    rnd_rdy = 1'b0; erdy[0] = 1'b1; erdy[1] = 1'b1;
    check_state("ext");
  endtask

  task automatic test_repeat();
    push(8'h1C); push(8'h1C); push(8'h1C);
    drain(300);
    check_state("repeat");
  endtask

  task automatic test_back_to_back();
    int n = 0;
    erdy[0] = 1'b0; erdy[1] = 1'b0;
    push(8'h15); push(8'h24);
    while (!(evv[0] && evv[1]) && n < 20) begin tick(); n++; end
    n_cmp++;
    if (!(evv[0] && evv[1])) begin n_err++;
      $display("FAIL bp_first_event: got %b%b want 11", evv[0], evv[1]); end
    repeat (10) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (nd_n[d] !== 1'b1 || evv[d] !== 1'b1) begin n_err++;
          $display("FAIL bp_hold dut%0d: got nd_n=%b v=%b want 1/1", d, nd_n[d], evv[d]); end
      end
    end
    erdy[0] = 1'b1; erdy[1] = 1'b1;
    tick();
    erdy[0] = 1'b0; erdy[1] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (evv[d] !== (k == 3)) begin n_err++;
          $display("FAIL bp_second_latency dut%0d cyc%0d: got %b want %b", d, k, evv[d], (k == 3)); end
      end
    end
    erdy[0] = 1'b1; erdy[1] = 1'b1;
    drain(200);
    check_state("backpressure");
  endtask

  task automatic test_random();
    logic [7:0] codes [6];
    int r;
    codes[0] = 8'h1C; codes[1] = 8'h1B; codes[2] = 8'h23;
    codes[3] = 8'h2B; codes[4] = 8'h75; codes[5] = 8'h6B;
    rnd_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 11);
      if (r < 3) push(8'hE0);
      if (r == 1) push(8'hE0);
      if (r % 3 == 0) push(8'hF0);
      if (r == 6) push(8'hF0);
      push(codes[$urandom_range(0, 5)]);
    end
    drain(6000);
    rnd_rdy = 1'b0; erdy[0] = 1'b1; erdy[1] = 1'b1;
    check_state("random");
  endtask

  task automatic test_wrap();
    logic [7:0] start [2];
    logic [7:0] c;
    start[0] = m_cnt[0]; start[1] = m_cnt[1];
    for (int i = 0; i < 256; i++) begin
      c = 8'(i >> 1) + 8'd1;
      if (i % 2 == 1) push(8'hE0);
      push(c);
      if (i % 2 == 1) push(8'hE0);
      push(8'hF0);
      push(c);
    end
    drain(30000);
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (pc[d] !== start[d]) begin n_err++;
        $display("FAIL wrap_count dut%0d: got %0d want %0d", d, pc[d], start[d]); end
    end
    check_state("wrap");
  endtask

  task automatic test_overflow();
    push(8'hF0);
    drain(100);
    ovf = 1'b1;
    tick();
    ovf = 1'b0;
    for (int d = 0; d < 2; d++) begin m_ext[d] = 1'b0; m_brk[d] = 1'b0; end
    tick();
    push(8'h1C);
    drain(200);
    check_state("overflow");
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (ovs[d] !== 1'b1) begin n_err++;
        $display("FAIL ovf_sticky_set dut%0d: got %b want 1", d, ovs[d]); end
    end
    ovf = 1'b1; ovf_clr = 1'b1;
    tick();
    ovf = 1'b0;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (ovs[d] !== 1'b1) begin n_err++;
        $display("FAIL ovf_set_wins dut%0d: got %b want 1", d, ovs[d]); end
    end
    tick();
    ovf_clr = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (ovs[d] !== 1'b0) begin n_err++;
        $display("FAIL ovf_clear dut%0d: got %b want 0", d, ovs[d]); end
    end
  endtask

  task automatic test_reset_ack();
    push(8'h2B);
    tick();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (nd_n[d] !== 1'b0) begin n_err++;
        $display("FAIL rst_ack_pre dut%0d: got %b want 0", d, nd_n[d]); end
    end
    #1 clrn = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if (nd_n[d] !== 1'b1) begin n_err++;
        $display("FAIL rst_ack_nd dut%0d: got %b want 1", d, nd_n[d]); end
    end
    @(posedge clk);
    #1 clrn = 1'b0;
    clear_tb();
    repeat (4) tick();
    for (int d = 0; d < 2; d++) begin
      n_cmp++;
      if ({nd_n[d], evv[d], hv[d], pc[d]} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin n_err++;
        $display("FAIL rst_ack_after dut%0d: got nd_n=%b v=%b hv=%b pc=%h want 1/0/0/00",
                 d, nd_n[d], evv[d], hv[d], pc[d]); end
    end
  endtask

  initial begin
    clrn = 1'b1; ovf = 1'b0; ovf_clr = 1'b0;
    erdy[0] = 1'b1; erdy[1] = 1'b1;
    clear_tb();
    repeat (3) @(posedge clk);
    #1 clrn = 1'b0;
    test_reset();
    test_make_break();
    test_ext();
    test_repeat();
    test_back_to_back();
    test_random();
    test_wrap();
    test_overflow();
    test_reset_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
